mem_stage: RTL

Memory-access stage of the five-stage MIPS pipeline. It consumes the 73-bit `EX_MEM` bundle produced by the execute stage and runs a request/ready handshake with the data memory for loads and stores. It registers the writeback bundle `MEM_WB` and drives the MEM-side forwarding signals back to execute. It stalls the front of the pipeline while a memory access is outstanding.

---
 rtl/mem_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory request/ready handshake, MEM_WB register, MEM-side forwarding.
// Optional build macro MEM_ALIGN_CHECK_EN enables the misaligned-access trap.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [72:0] EX_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        MEM_RegWrite,
  output logic [4:0]  MEM_WriteRegister,
  output logic [31:0] MEM_RegWriteData,
  output logic [37:0] MEM_WB,
  output logic        mem_bus_err,
  output logic        mem_align_err,
  output logic        o_dbg_state,
  output logic [3:0]  o_dbg_wait_cnt
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic [37:0] r_mem_wb, w_mem_wb_nxt;
  logic        r_bus_err, w_bus_err_nxt;
  logic        w_acc, w_misalign, w_go, w_abort;
  logic [31:0] w_wb_data;

  // Handshake: dmem_req is held with a stable address/data until dmem_ready
  // is seen high in the same cycle (transfer) or the wait counter expires.
  assign w_acc = EX_MEM[69] | (EX_MEM[71:70] == 2'b01);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_acc & (EX_MEM[33:32] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_go      = w_acc & ~w_misalign;
  assign w_abort   = (r_state == WAIT) & w_go & ~dmem_ready & (r_wait_cnt == LP_MAX_WAIT);
  assign w_wb_data = (EX_MEM[71:70] == 2'b01) ? dmem_rdata : EX_MEM[63:32];

  // Reset gates the request so an in-flight access is abandoned immediately.
  assign dmem_req   = w_go & rst_n;
  assign dmem_we    = EX_MEM[69];
  assign dmem_addr  = {EX_MEM[63:34], 2'b00};
  assign dmem_wdata = EX_MEM[31:0];
  assign mem_stall  = w_go & ~dmem_ready & ~w_abort & rst_n;

  assign MEM_RegWrite      = EX_MEM[72];
  assign MEM_WriteRegister = EX_MEM[68:64];
  assign MEM_RegWriteData  = EX_MEM[63:32];

  assign MEM_WB         = r_mem_wb;
  assign mem_bus_err    = r_bus_err;
  assign o_dbg_state    = r_state;
  assign o_dbg_wait_cnt = r_wait_cnt;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mem_wb_nxt   = {EX_MEM[72], EX_MEM[68:64], w_wb_data};
    w_bus_err_nxt  = 1'b0;
    if (w_misalign) begin
      w_mem_wb_nxt = '0;
    end
    case (r_state)
      IDLE: begin
        if (w_go && !dmem_ready) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = 4'd1;
          w_mem_wb_nxt   = '0;
        end
      end
      WAIT: begin
        if (!w_go || dmem_ready) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = 4'd0;
        end else if (w_abort) begin
          w_state_nxt    = IDLE;
          w_wait_cnt_nxt = 4'd0;
          w_bus_err_nxt  = 1'b1;
          w_mem_wb_nxt   = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          w_mem_wb_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_mem_wb   <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mem_wb   <= w_mem_wb_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_misalign;
    end
  end

  assign mem_align_err = r_align_err;
`else
  assign mem_align_err = 1'b0;
`endif

endmodule
